// File: rtl/game_pkg.sv
// game_pkg
// Shared type definitions for the game-side RTL.
//   move_state_t : states of the player move sequencer (IDLE, QUERY, MOVE)
//   dir_t        : direction / facing encoding, 0 = up, 1 = down, 2 = left, 3 = right
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_MOVE  = 2'd2
    } move_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

endpackage

// File: rtl/move_bounds_check.sv
// move_bounds_check
// Computes the tile-aligned target position one tile away from the current
// position in the requested direction, and flags when that target would leave
// the legal play area.
//   pos_x, pos_y   : current top-left pixel position of the player
//   dir            : requested direction of travel
//   target_x/y     : position one tile away (only meaningful when in bounds)
//   out_of_bounds  : 1 when the target would be below 0 or above X_MAX/Y_MAX
module move_bounds_check
    import game_pkg::*;
#(
    parameter int TILE  = 16,
    parameter int X_MAX = 1008,
    parameter int Y_MAX = 752
) (
    input  logic [10:0] pos_x,
    input  logic [9:0]  pos_y,
    input  dir_t        dir,
    output logic [10:0] target_x,
    output logic [9:0]  target_y,
    output logic        out_of_bounds
);

    localparam logic [10:0] TILE_X       = 11'(TILE);
    localparam logic [9:0]  TILE_Y       = 10'(TILE);
    localparam logic [10:0] X_LAST_START = 11'(X_MAX - TILE);
    localparam logic [9:0]  Y_LAST_START = 10'(Y_MAX - TILE);

    // The limits are compared against the current position before any add or
    // subtract happens, so an unsigned underflow or overflow can never make an
    // illegal target look legal.
    always_comb begin
        target_x      = pos_x;
        target_y      = pos_y;
        out_of_bounds = 1'b0;
        unique case (dir)
            DIR_UP: begin
                if (pos_y < TILE_Y) out_of_bounds = 1'b1;
                else                target_y      = pos_y - TILE_Y;
            end
            DIR_DOWN: begin
                if (pos_y > Y_LAST_START) out_of_bounds = 1'b1;
                else                      target_y      = pos_y + TILE_Y;
            end
            DIR_LEFT: begin
                if (pos_x < TILE_X) out_of_bounds = 1'b1;
                else                target_x      = pos_x - TILE_X;
            end
            DIR_RIGHT: begin
                if (pos_x > X_LAST_START) out_of_bounds = 1'b1;
                else                      target_x      = pos_x + TILE_X;
            end
        endcase
    end

endmodule

// File: rtl/player_move_sequencer.sv
// player_move_sequencer
// Turns level-sensitive direction buttons into tile-by-tile player moves.
// Once per frame it picks a direction, checks the play-area bounds, asks the
// collision map whether the target tile is passable, then slides the player
// STEP pixels per frame until the target tile is reached.
//   vclk, reset            : pixel clock, synchronous active-high reset
//   hcount, vcount         : raster position, frame tick is at (0,0)
//   up, down, left, right  : direction buttons
//   tile_req, tile_col/row : collision lookup request and target tile
//   tile_ack, tile_blocked : lookup response (blocked valid with ack)
//   player_x, player_y     : current top-left pixel position
//   facing                 : last direction chosen (game_pkg::dir_t encoding)
//   moving                 : high while sliding between tiles
//   bump                   : one-cycle pulse when a move is refused
// TILE must be an integer multiple of STEP so the slide lands exactly on the
// target.
module player_move_sequencer
    import game_pkg::*;
#(
    parameter int TILE  = 16,
    parameter int STEP  = 2,
    parameter int X_MAX = 1008,
    parameter int Y_MAX = 752,
    parameter int X_RST = 0,
    parameter int Y_RST = 80
) (
    input  logic        vclk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    output logic        tile_req,
    output logic [5:0]  tile_col,
    output logic [5:0]  tile_row,
    input  logic        tile_ack,
    input  logic        tile_blocked,
    output logic [10:0] player_x,
    output logic [9:0]  player_y,
    output logic [1:0]  facing,
    output logic        moving,
    output logic        bump
);

    localparam logic [10:0] STEP_X = 11'(STEP);
    localparam logic [9:0]  STEP_Y = 10'(STEP);
    localparam logic [10:0] TILE_X = 11'(TILE);
    localparam logic [9:0]  TILE_Y = 10'(TILE);

    move_state_t state, state_next;
    dir_t        face_q, face_next;
    dir_t        req_dir;
    logic [10:0] target_x_q, target_x_next, x_next;
    logic [9:0]  target_y_q, target_y_next, y_next;
    logic        bump_next;
    logic        frame_tick;
    logic        any_button;
    logic [10:0] cand_x;
    logic [9:0]  cand_y;
    logic        cand_oob;

    assign frame_tick = (hcount == 11'd0) && (vcount == 10'd0);
    assign any_button = up | down | left | right;

    // Fixed button priority: up beats down beats left beats right, so
    // pressing two buttons at once always resolves to the same direction.
    always_comb begin
        req_dir = DIR_RIGHT;
        if (up)        req_dir = DIR_UP;
        else if (down) req_dir = DIR_DOWN;
        else if (left) req_dir = DIR_LEFT;
    end

    move_bounds_check #(
        .TILE (TILE),
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_bounds (
        .pos_x        (player_x),
        .pos_y        (player_y),
        .dir          (req_dir),
        .target_x     (cand_x),
        .target_y     (cand_y),
        .out_of_bounds(cand_oob)
    );

    // The lookup coordinates come straight from the registered target, which
    // only changes in IDLE, so they stay put for the whole QUERY wait.
    assign tile_req = (state == ST_QUERY);
    assign moving   = (state == ST_MOVE);
    assign facing   = face_q;
    assign tile_col = 6'(target_x_q / TILE_X);
    assign tile_row = 6'(target_y_q / TILE_Y);

    // Next-state and datapath decisions. In IDLE a frame tick with a button
    // held commits the facing even if the move is later refused. QUERY waits
    // for the ack with no timeout and ignores frame ticks. MOVE advances one
    // step per frame and drops back to IDLE on the tick that lands on target.
    always_comb begin
        state_next    = state;
        face_next     = face_q;
        target_x_next = target_x_q;
        target_y_next = target_y_q;
        x_next        = player_x;
        y_next        = player_y;
        bump_next     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_tick && any_button) begin
                    face_next = req_dir;
                    if (cand_oob) begin
                        bump_next = 1'b1;
                    end else begin
                        state_next    = ST_QUERY;
                        target_x_next = cand_x;
                        target_y_next = cand_y;
                    end
                end
            end
            ST_QUERY: begin
                if (tile_ack) begin
                    if (tile_blocked) begin
                        state_next = ST_IDLE;
                        bump_next  = 1'b1;
                    end else begin
                        state_next = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (frame_tick) begin
                    unique case (face_q)
                        DIR_UP:    y_next = player_y - STEP_Y;
                        DIR_DOWN:  y_next = player_y + STEP_Y;
                        DIR_LEFT:  x_next = player_x - STEP_X;
                        DIR_RIGHT: x_next = player_x + STEP_X;
                    endcase
                    if ((x_next == target_x_q) && (y_next == target_y_q)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers. Reset discards any lookup or partial
    // slide and puts the player back at the spawn point facing down.
    always_ff @(posedge vclk) begin
        if (reset) begin
            state      <= ST_IDLE;
            face_q     <= DIR_DOWN;
            player_x   <= 11'(X_RST);
            player_y   <= 10'(Y_RST);
            target_x_q <= 11'(X_RST);
            target_y_q <= 10'(Y_RST);
            bump       <= 1'b0;
        end else begin
            state      <= state_next;
            face_q     <= face_next;
            player_x   <= x_next;
            player_y   <= y_next;
            target_x_q <= target_x_next;
            target_y_q <= target_y_next;
            bump       <= bump_next;
        end
    end

endmodule

// File: tb/tb_player_move_sequencer.sv
// tb_player_move_sequencer
// Self-checking bench for player_move_sequencer. A compressed raster (short
// lines, few rows) makes frame ticks frequent. A reference model tracks the
// player as "start position plus frames travelled times step" and is compared
// with the DUT on every negative edge; directed scenarios pin literal values.
module tb_player_move_sequencer;

    localparam int TILE    = 16;
    localparam int STEP    = 2;
    localparam int X_MAX   = 64;
    localparam int Y_MAX   = 128;
    localparam int X_RST   = 0;
    localparam int Y_RST   = 80;
    localparam int H_TOTAL = 6;
    localparam int V_TOTAL = 3;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic        vclk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        tile_req;
    logic [5:0]  tile_col, tile_row;
    logic        tile_ack = 1'b0, tile_blocked = 1'b0;
    logic [10:0] player_x;
    logic [9:0]  player_y;
    logic [1:0]  facing;
    logic        moving, bump;

    int errors = 0;
    int checks = 0;

    // Responder configuration: ack_delay 0 means never acknowledge.
    int  ack_delay = 3;
    bit  blk_cfg   = 1'b0;
    bit  rand_mode = 1'b0;
    int  req_age   = 0;
    int  cur_delay = 0;

    // Reference model state.
    bit  m_valid = 1'b0;
    bit  m_look, m_move, m_bump;
    int  m_x, m_y, m_face, m_tx, m_ty, m_sx, m_sy, m_frames;

    // Directed-scenario scratch.
    bit  seen, saw_move, saw_req, done, stable;
    int  prev_x, steps, bad, ticks, bumps, c0, r0, x0, y0;

    always #5 vclk = ~vclk;

    player_move_sequencer #(
        .TILE (TILE),
        .STEP (STEP),
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .X_RST(X_RST),
        .Y_RST(Y_RST)
    ) dut (
        .vclk        (vclk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .tile_req    (tile_req),
        .tile_col    (tile_col),
        .tile_row    (tile_row),
        .tile_ack    (tile_ack),
        .tile_blocked(tile_blocked),
        .player_x    (player_x),
        .player_y    (player_y),
        .facing      (facing),
        .moving      (moving),
        .bump        (bump)
    );

    // Shared comparison routine used by both the continuous compare and the
    // directed scenarios.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Buttons are packed {up, down, left, right}; inputs change 1 time unit
    // after the rising edge so the DUT and model both see stable values.
    task automatic applyStimulus(input logic [3:0] btn, input logic rst);
        @(posedge vclk);
        #1;
        {up, down, left, right} = btn;
        reset = rst;
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
    endtask

    task automatic waitReq(output bit found);
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge vclk);
            if (tile_req) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Compressed raster: frame tick every FRAME cycles.
    initial begin
        hcount = '0;
        vcount = '0;
        forever begin
            @(posedge vclk);
            #1;
            if (int'(hcount) == H_TOTAL - 1) begin
                hcount = '0;
                vcount = (int'(vcount) == V_TOTAL - 1) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
        end
    end

    // Collision-map stand-in: acknowledges after a configurable number of
    // request cycles; in random mode the delay and verdict are random and
    // stray acks are thrown in while no request is pending.
    initial begin
        forever begin
            @(posedge vclk);
            #1;
            tile_ack     = 1'b0;
            tile_blocked = rand_mode ? 1'($urandom_range(0, 1)) : blk_cfg;
            if (tile_req) begin
                req_age++;
                if (req_age == 1) cur_delay = rand_mode ? int'($urandom_range(1, 5)) : ack_delay;
                if (cur_delay > 0 && req_age == cur_delay) begin
                    tile_ack     = 1'b1;
                    tile_blocked = rand_mode ? ($urandom_range(0, 3) == 0) : blk_cfg;
                end
            end else begin
                req_age = 0;
                if (rand_mode && $urandom_range(0, 7) == 0) tile_ack = 1'b1;
            end
        end
    end

    // Reference model: a pending lookup, a slide measured in frames since
    // the lookup was granted, or neither. Positions use signed integers so the
    // bounds test is a plain range check.
    always @(posedge vclk) begin : ref_model
        int  d, tx, ty, dx, dy;
        bit  tick;
        if (reset) begin
            m_valid = 1'b1;
            m_x = X_RST; m_y = Y_RST; m_face = 1;
            m_look = 1'b0; m_move = 1'b0; m_bump = 1'b0;
        end else if (m_valid) begin
            tick   = (hcount == 11'd0) && (vcount == 10'd0);
            m_bump = 1'b0;
            dx = (m_face == 2) ? -1 : (m_face == 3) ? 1 : 0;
            dy = (m_face == 0) ? -1 : (m_face == 1) ? 1 : 0;
            if (m_look) begin
                if (tile_ack) begin
                    m_look = 1'b0;
                    if (tile_blocked) m_bump = 1'b1;
                    else begin m_move = 1'b1; m_frames = 0; end
                end
            end else if (m_move) begin
                if (tick) begin
                    m_frames++;
                    m_x = m_sx + dx * STEP * m_frames;
                    m_y = m_sy + dy * STEP * m_frames;
                    if (m_frames == TILE / STEP) m_move = 1'b0;
                end
            end else if (tick && (up || down || left || right)) begin
                d  = up ? 0 : down ? 1 : left ? 2 : 3;
                m_face = d;
                tx = m_x + ((d == 2) ? -TILE : (d == 3) ? TILE : 0);
                ty = m_y + ((d == 0) ? -TILE : (d == 1) ? TILE : 0);
                if (tx < 0 || tx > X_MAX || ty < 0 || ty > Y_MAX) begin
                    m_bump = 1'b1;
                end else begin
                    m_look = 1'b1;
                    m_tx = tx; m_ty = ty; m_sx = m_x; m_sy = m_y;
                end
            end
        end
    end

    // Continuous compare of every output against the model, away from the
    // active edge.
    always @(negedge vclk) begin
        if (m_valid) begin
            checkOutput("tile_req", int'(tile_req), int'(m_look));
            if (m_look) begin
                checkOutput("tile_col", int'(tile_col), m_tx / TILE);
                checkOutput("tile_row", int'(tile_row), m_ty / TILE);
            end
            checkOutput("player_x", int'(player_x), m_x);
            checkOutput("player_y", int'(player_y), m_y);
            checkOutput("facing", int'(facing), m_face);
            checkOutput("moving", int'(moving), int'(m_move));
            checkOutput("bump", int'(bump), int'(m_bump));
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        doReset();
        @(negedge vclk);
        checkOutput("rst_x", int'(player_x), 0);
        checkOutput("rst_y", int'(player_y), 80);
        checkOutput("rst_facing", int'(facing), 1);
        checkOutput("rst_tile_req", int'(tile_req), 0);
        checkOutput("rst_moving", int'(moving), 0);
        checkOutput("rst_bump", int'(bump), 0);

        $display("[TB] right move, unblocked lookup");
        ack_delay = 3; blk_cfg = 1'b0;
        applyStimulus(4'b0001, 1'b0);
        waitReq(seen);
        checkOutput("right_lookup_seen", int'(seen), 1);
        applyStimulus(4'b0000, 1'b0);
        prev_x = int'(player_x); steps = 0; bad = 0; ticks = 0; saw_move = 0; done = 0;
        for (int i = 0; i < 40 * FRAME; i++) begin
            @(negedge vclk);
            if (moving) begin
                saw_move = 1'b1;
                if (hcount == 11'd0 && vcount == 10'd0) ticks++;
            end
            if (int'(player_x) != prev_x) begin
                steps++;
                if (int'(player_x) != prev_x + 2) bad++;
                prev_x = int'(player_x);
            end
            if (saw_move && !moving) begin done = 1'b1; break; end
        end
        checkOutput("right_move_done", int'(done), 1);
        checkOutput("right_steps", steps, 8);
        checkOutput("right_frames_moving", ticks, 8);
        checkOutput("right_step_size_errs", bad, 0);
        checkOutput("right_final_x", int'(player_x), 16);
        checkOutput("right_facing", int'(facing), 3);

        $display("[TB] up move into blocked tile");
        doReset();
        blk_cfg = 1'b1;
        applyStimulus(4'b1000, 1'b0);
        waitReq(seen);
        checkOutput("blocked_lookup_seen", int'(seen), 1);
        applyStimulus(4'b0000, 1'b0);
        bumps = 0; saw_move = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge vclk);
            if (bump) bumps++;
            if (moving) saw_move = 1'b1;
        end
        checkOutput("blocked_bumps", bumps, 1);
        checkOutput("blocked_moving_seen", int'(saw_move), 0);
        checkOutput("blocked_y", int'(player_y), 80);
        checkOutput("blocked_facing", int'(facing), 0);
        blk_cfg = 1'b0;

        $display("[TB] left at x=0 leaves the play area");
        doReset();
        applyStimulus(4'b0010, 1'b0);
        saw_req = 0; seen = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge vclk);
            if (tile_req) saw_req = 1'b1;
            if (bump) begin seen = 1'b1; break; end
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("oob_bump_seen", int'(seen), 1);
        checkOutput("oob_tile_req_seen", int'(saw_req), 0);
        checkOutput("oob_x", int'(player_x), 0);
        checkOutput("oob_facing", int'(facing), 2);

        $display("[TB] up+left priority");
        doReset();
        blk_cfg = 1'b1;
        applyStimulus(4'b1010, 1'b0);
        waitReq(seen);
        checkOutput("prio_lookup_seen", int'(seen), 1);
        checkOutput("prio_tile_row", int'(tile_row), 4);
        checkOutput("prio_tile_col", int'(tile_col), 0);
        checkOutput("prio_facing", int'(facing), 0);
        applyStimulus(4'b0000, 1'b0);
        blk_cfg = 1'b0;

        $display("[TB] reset in the middle of a move");
        doReset();
        applyStimulus(4'b0001, 1'b0);
        waitReq(seen);
        applyStimulus(4'b0000, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 * FRAME; i++) begin
            @(negedge vclk);
            if (int'(player_x) == 6) begin seen = 1'b1; break; end
        end
        checkOutput("midmove_reached_x6", int'(seen), 1);
        applyStimulus(4'b0000, 1'b1);
        @(posedge vclk);
        @(negedge vclk);
        checkOutput("midmove_rst_x", int'(player_x), 0);
        checkOutput("midmove_rst_y", int'(player_y), 80);
        checkOutput("midmove_rst_moving", int'(moving), 0);
        checkOutput("midmove_rst_tile_req", int'(tile_req), 0);
        applyStimulus(4'b0000, 1'b0);
        saw_req = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge vclk);
            if (tile_req || moving) saw_req = 1'b1;
        end
        checkOutput("midmove_activity_after_rst", int'(saw_req), 0);

        $display("[TB] lookup never acknowledged for 100 frames");
        ack_delay = 0;
        doReset();
        applyStimulus(4'b0100, 1'b0);
        waitReq(seen);
        checkOutput("noack_lookup_seen", int'(seen), 1);
        applyStimulus(4'b0000, 1'b0);
        c0 = int'(tile_col); r0 = int'(tile_row); x0 = int'(player_x); y0 = int'(player_y);
        stable = 1'b1;
        for (int i = 0; i < 100 * FRAME; i++) begin
            @(negedge vclk);
            if (!tile_req || int'(tile_col) != c0 || int'(tile_row) != r0 ||
                int'(player_x) != x0 || int'(player_y) != y0) stable = 1'b0;
        end
        checkOutput("noack_stable", int'(stable), 1);
        checkOutput("noack_tile_row", r0, 6);
        checkOutput("noack_tile_col", c0, 0);
        checkOutput("noack_y", y0, 80);
        ack_delay = 3;
        doReset();

        $display("[TB] randomized run");
        rand_mode = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0)
                applyStimulus(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom), 1'b0);
            else if ($urandom_range(0, 1999) == 0)
                applyStimulus({up, down, left, right}, 1'b1);
            else
                applyStimulus({up, down, left, right}, 1'b0);
        end
        rand_mode = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        @(negedge vclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_move_sequencer.md
PLAYER_MOVE_SEQUENCER -- requirements
Module: player_move_sequencer

Interface
REQ-001 Parameter TILE, default 16, tile edge in pixels; every move is exactly one tile.
REQ-002 Parameter STEP, default 2, pixels advanced per frame tick while moving; TILE SHALL be an integer multiple of STEP.
REQ-003 Parameters X_MAX, default 1008, and Y_MAX, default 752: largest legal player_x and player_y (top-left corner of the tile).
REQ-004 Parameters X_RST, default 0, and Y_RST, default 80: player_x and player_y after reset.
REQ-005 vclk  in  1  sole clock; every flop is clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 hcount  in  11  pixel column.
REQ-008 vcount  in  10  pixel row.
REQ-009 up, down, left, right  in  1 each  level-sensitive direction buttons.
REQ-010 tile_req  out  1  collision-map lookup request.
REQ-011 tile_col, tile_row  out  6 each  target tile coordinates (pixel position / TILE).
REQ-012 tile_ack  in  1  lookup done; tile_blocked is valid in the same cycle.
REQ-013 tile_blocked  in  1  1 = target tile impassable.
REQ-014 player_x  out  11, player_y  out  10  current pixel position.
REQ-015 facing  out  2  direction faced: 0 = up, 1 = down, 2 = left, 3 = right.
REQ-016 moving  out  1  high while in state MOVE.
REQ-017 bump  out  1  one-cycle pulse when a move is refused.

Function
REQ-018 frame_tick SHALL be 1 exactly in the cycle where hcount==0 and vcount==0.
REQ-019 States SHALL be IDLE, QUERY and MOVE.
REQ-020 IDLE: on frame_tick with any button high, the block SHALL latch one direction with priority up > down > left > right, set facing to it and compute the target position (current position +/- TILE on one axis).
REQ-021 If the target would be below 0 or above X_MAX/Y_MAX, the block SHALL stay in IDLE, leave the position unchanged and pulse bump the next cycle; the bound check SHALL NOT rely on arithmetic wrap-around.
REQ-022 Otherwise the block SHALL enter QUERY the next cycle, driving tile_req=1 and tile_col/tile_row from the target; these outputs SHALL be held stable until tile_ack.
REQ-023 QUERY has no timeout; frame ticks during QUERY SHALL be ignored.
REQ-024 On tile_ack with tile_blocked=1, the block SHALL drop tile_req in the next cycle, return to IDLE and pulse bump for one cycle.
REQ-025 On tile_ack with tile_blocked=0, the block SHALL drop tile_req in the next cycle and enter MOVE.
REQ-026 MOVE: on each frame_tick, the active axis SHALL step STEP pixels toward the target; the first step SHALL occur on the first frame_tick after entry.
REQ-027 When the position equals the target, the block SHALL return to IDLE in the same cycle; a default move takes TILE/STEP = 8 frames.
REQ-028 Buttons SHALL be ignored outside IDLE; a move in progress SHALL NOT be cancelled or redirected.
REQ-029 A button held continuously SHALL start the next move on the first frame_tick in IDLE after arrival.
REQ-030 tile_ack arriving outside QUERY SHALL be ignored.

Reset
REQ-031 On reset, state SHALL be IDLE, player_x=X_RST, player_y=Y_RST, facing=1 (down), and tile_req, moving and bump SHALL all be 0.
REQ-032 Reset SHALL abort QUERY or MOVE immediately, with no further tile_req after it; a partial move SHALL be discarded.

Structure
REQ-033 The state enum and the facing/direction encoding SHALL live in the shared package game_pkg.
REQ-034 Frame-tick detection and direction priority SHALL be inline.
REQ-035 The one natural sub-module, move_bounds_check, SHALL compute the target position and the out-of-bounds flag combinationally.

Verification
REQ-036 Press right from reset, lookup acked unblocked 3 cycles after tile_req -> facing=3, moving for 8 frames, player_x 0->16 in steps of 2, then IDLE.
REQ-037 Press up at (0,80), tile_blocked=1 -> one bump pulse, player_y stays 80, facing=0, moving never asserts.
REQ-038 Press left at x=0 -> no tile_req, bump pulse, player_x stays 0.
REQ-039 Press up+left together at (0,80) -> facing=0 and the lookup is for tile_row=4, tile_col=0.
REQ-040 Apply reset mid-MOVE at x=6 -> next cycle x=0, y=80, moving=0, state IDLE.
REQ-041 Hold tile_ack low for 100 frames -> tile_req and its coordinates stay stable and the position is unchanged.
